conv55_sched: RTL and testbench
===============================

# conv55_sched

Sequencing controller for the 5x5 convolution window datapath (`conv55`) in the LeNet-5 BRAM pipeline. On `start` it walks an IMG_H x IMG_W feature map in row-major window order. It issues column reads to the feature-map BRAM wrapper, which returns five vertically stacked pixels per read, and gates the window shift enable. It captures every full-window result into an output FIFO with its (row, col) coordinate, honours downstream backpressure through a credit counter, and pulses `done` when the map is finished.

## Interface
- BIT_WIDTH, 8: pixel and weight width, signed
- OUT_WIDTH, 32: result width, signed
- IMG_W, 32: feature-map width in pixels, must be at least 5
- IMG_H, 32: feature-map height in pixels, must be at least 5
- FIFO_DEPTH, 4: output FIFO entries, power of 2, at least 4
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin one map pass; honoured only in IDLE
- filter  in  25*BIT_WIDTH  5x5 weights; must be held stable from `start` to `done`
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at the end of a pass
- rd_en  out  1  BRAM column read strobe
- rd_row  out  clog2(IMG_H)  top row of the 5-row band
- rd_col  out  clog2(IMG_W)  column being read
- rd_data  in  5*BIT_WIDTH  rows rd_row..rd_row+4 at rd_col; valid exactly 1 cycle after rd_en; row 0 is in the LSBs
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head on out_valid&&out_ready
- out_data  out  OUT_WIDTH  convolution sum
- out_row, out_col  out  clog2(IMG_H), clog2(IMG_W)  top-left corner of the window

## Operation
- FSM states:
  - IDLE: `start` moves to RUN and clears the row/column counters.
  - RUN: issues reads. Moves to DRAIN after the read at (IMG_H-5, IMG_W-1).
  - DRAIN: waits until no read is in flight and the FIFO is empty.
  - DONE: lasts one cycle with `done`=1, then returns to IDLE.
- Read order: rd_row runs 0..IMG_H-5 and rd_col runs 0..IMG_W-1, with the column counter fastest. At a column wrap the row counter increments and the window refills from scratch.
- A read is issued in RUN only when credits > 0. It is issued whether or not it will produce a result.
- Each read's rd_data is presented to the internal `conv55` as in1..in5 with en=1 on the cycle the data returns.
- A read at column c produces a result only if c >= 4. The result coordinate is (rd_row, c-4).
- Results: outputs per pass = (IMG_H-4)*(IMG_W-4). Windows never straddle two bands.
- Credits = FIFO_DEPTH - fifo_count - producing reads in flight. Reads that produce no result do not consume credits. A same-cycle FIFO pop is counted in the cycle it occurs.
- Arithmetic: the datapath produces signed products and sums in OUT_WIDTH. Overflow wraps and is not detected.
- `start` while busy is ignored. out_ready is ignored while the FIFO is empty.
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, counters 0. Reset mid-pass drops all in-flight reads and FIFO contents with no `done` pulse.

## Timing
- Read issued at cycle t. Data returns and the window shifts at the end of t+1. The sum is stable in t+2 and written to the FIFO at the end of t+2. out_valid can rise at t+3.
- Issue-to-out_valid latency is 3 cycles with the FIFO empty.
- With out_ready held high the pass takes (IMG_H-4)*IMG_W issue cycles, plus pipeline drain, plus the DONE cycle. After the first `start` there are no bubbles.
- With out_ready=0, at most FIFO_DEPTH results are outstanding, so the FIFO never overflows. Non-producing warm-up reads continue regardless of credits.
- out_data, out_row and out_col are held stable while out_valid && !out_ready.
- `done` rises the cycle after the last FIFO pop and the DRAIN exit.

## Structure
- Shared package holds:
  - FSM state enum {IDLE, RUN, DRAIN, DONE}
  - window constant K=5
  - coordinate width functions
- Instantiates one `conv55` as the datapath.
- One sub-module, `conv_res_fifo`: a synchronous FIFO holding {data, row, col}, with count output, first-word fall-through, and async active-low reset.

## Test plan
- IMG_W=8, IMG_H=6, all pixels=1, all weights=1, out_ready=1. Required: 8 outputs of 25 at coordinates (0,0)..(1,3) in order, then `done` after the drain; no outputs for band-start columns 0..3.
- Pixel = row*8+col, weights are a single 1 at tap (0,0), otherwise 0. Required: each out_data equals the top-left pixel of its window, e.g. (1,2) gives 10.
- out_ready=0 for 40 cycles mid-pass. Required: exactly 4 results buffered, rd_en continues only for non-producing columns, no data loss or duplication after release.
- Signed extremes, pixels=-128 and weights=-128. Required: every output is 409600.
- Assert rst_n low during RUN, then restart. Required: outputs zero, no `done`, and the second pass produces the full correct sequence.
- `start` pulsed during RUN. Required: ignored, exactly one `done` per pass.

Source files
------------

// File: rtl/conv55_sched_pkg.sv
// Shared types and sizing helpers for the conv55 window scheduler.
package conv55_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int K = 5;

  // Width of a coordinate counter able to index 0..n-1.
  function automatic int coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/conv55.sv
// 5x5 sliding-window convolution: shifts in one 5-pixel column per enable,
// and presents the signed sum of the current window combinationally.
module conv55
  import conv55_sched_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [BIT_WIDTH-1:0]         in1,
  input  logic [BIT_WIDTH-1:0]         in2,
  input  logic [BIT_WIDTH-1:0]         in3,
  input  logic [BIT_WIDTH-1:0]         in4,
  input  logic [BIT_WIDTH-1:0]         in5,
  input  logic [K*K*BIT_WIDTH-1:0]     filter,
  output logic [OUT_WIDTH-1:0]         sum
);

  // win[r][k]: row r of the band, k=0 is the oldest (leftmost) column.
  logic [BIT_WIDTH-1:0] win [K][K];
  logic [BIT_WIDTH-1:0] col_in [K];

  always_comb begin
    col_in[0] = in1;
    col_in[1] = in2;
    col_in[2] = in3;
    col_in[3] = in4;
    col_in[4] = in5;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int k = 0; k < K; k++)
          win[r][k] <= '0;
    end else if (en) begin
      for (int r = 0; r < K; r++) begin
        for (int k = 0; k < K-1; k++)
          win[r][k] <= win[r][k+1];
        win[r][K-1] <= col_in[r];
      end
    end
  end

  logic signed [OUT_WIDTH-1:0] acc, px, wt;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    acc = '0;
    px  = '0;
    wt  = '0;
    for (int r = 0; r < K; r++) begin
      for (int k = 0; k < K; k++) begin
        px  = OUT_WIDTH'($signed(win[r][k]));
        wt  = OUT_WIDTH'($signed(filter[(r*K+k)*BIT_WIDTH +: BIT_WIDTH]));
        acc = acc + px * wt;
      end
    end
  end

  assign sum = acc;

endmodule

// File: rtl/conv55_sched_fifo.sv
// First-word fall-through result FIFO with occupancy count; the head reads as
// zero while empty so the outputs are clean out of reset.
module conv_res_fifo
  import conv55_sched_pkg::*;
#(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    ready,
  output logic                    valid,
  output logic [WIDTH-1:0]        data,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count_q;
  logic             pop, push_ok;

  always_comb begin
    pop     = ready && (count_q != '0);
    push_ok = push && ((count_q != CW'(DEPTH)) || pop);
  end

  // NOTE: storage is deliberately not reset; only pointers and count are, which is enough to make it empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop);
    end
  end

  assign valid = (count_q != '0);
  assign data  = valid ? mem[rptr] : '0;
  assign count = count_q;

endmodule

// File: rtl/conv55_sched.sv
// Sequencer for the conv55 datapath: walks the map in 5-row bands, issues
// column reads under credit control and queues each full-window result.
module conv55_sched
  import conv55_sched_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [K*K*BIT_WIDTH-1:0]     filter,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [coord_w(IMG_H)-1:0]    rd_row,
  output logic [coord_w(IMG_W)-1:0]    rd_col,
  input  logic [K*BIT_WIDTH-1:0]       rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic [coord_w(IMG_H)-1:0]    out_row,
  output logic [coord_w(IMG_W)-1:0]    out_col
);

  localparam int RW  = coord_w(IMG_H);
  localparam int CLW = coord_w(IMG_W);
  localparam int CW  = cnt_w(FIFO_DEPTH);
  localparam int EW  = OUT_WIDTH + RW + CLW;

  state_t           state;
  logic [RW-1:0]    row;
  logic [CLW-1:0]   col;

  logic             s1_v, s1_prod, s2_prod;
  logic [RW-1:0]    s1_row, s2_row;
  logic [CLW-1:0]   s1_col, s2_col;

  logic [OUT_WIDTH-1:0] sum;
  logic [CW-1:0]        count;
  logic [EW-1:0]        head;

  logic          rd_prod, pop, has_credit, can_issue, last_rd, drained;
  logic [CW:0]   used;

  // Credits count results already queued plus producing reads at every pipeline stage.
  always_comb begin
    rd_prod    = rd_en && (rd_col >= CLW'(K-1));
    pop        = out_valid && out_ready;
    used       = {1'b0, count} + (CW+1)'(rd_prod) + (CW+1)'(s1_v && s1_prod)
               + (CW+1)'(s2_prod) - (CW+1)'(pop);
    has_credit = used < (CW+1)'(FIFO_DEPTH);
    can_issue  = (col < CLW'(K-1)) || has_credit;
    last_rd    = (row == RW'(IMG_H-K)) && (col == CLW'(IMG_W-1));
    drained    = !rd_en && !s1_v && !s2_prod && (count == CW'(pop));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      row    <= '0;
      col    <= '0;
      rd_en  <= 1'b0;
      rd_row <= '0;
      rd_col <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
          end
        end
        RUN: begin
          if (can_issue) begin
            rd_en  <= 1'b1;
            rd_row <= row;
            rd_col <= col;
            if (col == CLW'(IMG_W-1)) begin
              col <= '0;
              if (last_rd) state <= DRAIN;
              else         row   <= row + RW'(1);
            end else begin
              col <= col + CLW'(1);
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: data returning and window shifting; stage 2: sum ready for the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_prod <= 1'b0;
      s1_row  <= '0;
      s1_col  <= '0;
      s2_prod <= 1'b0;
      s2_row  <= '0;
      s2_col  <= '0;
    end else begin
      s1_v    <= rd_en;
      s1_prod <= rd_prod;
      s1_row  <= rd_row;
      s1_col  <= rd_col - CLW'(K-1);
      s2_prod <= s1_v && s1_prod;
      s2_row  <= s1_row;
      s2_col  <= s1_col;
    end
  end

  conv55 #(
    .BIT_WIDTH (BIT_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (s1_v),
    .in1    (rd_data[0*BIT_WIDTH +: BIT_WIDTH]),
    .in2    (rd_data[1*BIT_WIDTH +: BIT_WIDTH]),
    .in3    (rd_data[2*BIT_WIDTH +: BIT_WIDTH]),
    .in4    (rd_data[3*BIT_WIDTH +: BIT_WIDTH]),
    .in5    (rd_data[4*BIT_WIDTH +: BIT_WIDTH]),
    .filter (filter),
    .sum    (sum)
  );

  conv_res_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s2_prod),
    .push_data ({sum, s2_row, s2_col}),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (head),
    .count     (count)
  );

  assign {out_data, out_row, out_col} = head;

endmodule

// File: tb/tb_conv55_sched.sv
// Directed bench for conv55_sched on an 8x6 map with a behavioural BRAM model.
module tb_conv55_sched;

  localparam int W = 8;
  localparam int H = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [199:0] filter = '0;
  logic [39:0]  rd_data = '0;
  logic         busy, done, rd_en, out_valid;
  logic [2:0]   rd_row, rd_col, out_row, out_col;
  logic [31:0]  out_data;

  conv55_sched #(
    .BIT_WIDTH (8),
    .OUT_WIDTH (32),
    .IMG_W     (W),
    .IMG_H     (H),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .filter    (filter),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int cyc = 0;
  int q_row[$];
  int q_col[$];
  logic [31:0] q_data[$];
  int done_cnt = 0, prod_rd = 0, np_rd = 0;
  int lat = -1, lat_t0 = 0;
  bit lat_arm = 1'b0;
  logic prev_valid = 1'b0;

  function automatic logic [7:0] pix(input int m, input int r, input int c);
    if (m == 0)      return 8'd1;
    else if (m == 1) return 8'(r*8 + c);
    else             return 8'h80;
  endfunction

  function automatic int exp_val(input int m, input int r, input int c);
    if (m == 0)      return 25;
    else if (m == 1) return r*8 + c;
    else             return 409600;
  endfunction

  always @(posedge clk) begin
    if (rd_en)
      for (int i = 0; i < 5; i++)
        rd_data[i*8 +: 8] <= pix(mode, int'(rd_row) + i, int'(rd_col));
  end

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        q_row.push_back(int'(out_row));
        q_col.push_back(int'(out_col));
        q_data.push_back(out_data);
      end
      if (done) done_cnt++;
      if (rd_en) begin
        if (rd_col >= 3'd4) prod_rd++;
        else                np_rd++;
      end
      if (rd_en && rd_row == 3'd0 && rd_col == 3'd4) begin
        lat_t0  = cyc;
        lat_arm = 1'b1;
      end
      if (lat_arm && out_valid && !prev_valid) begin
        lat     = cyc - lat_t0;
        lat_arm = 1'b0;
      end
    end
    prev_valid = out_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_filter(input int m);
    for (int i = 0; i < 25; i++)
      filter[i*8 +: 8] = (m == 0) ? 8'd1 : (m == 1) ? ((i == 0) ? 8'd1 : 8'd0) : 8'h80;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) step(1);
    check(tag, done_cnt - d0, 1);
  endtask

  task automatic check_seq(input int base, input int m, input string tag);
    check({tag, "_count"}, q_data.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < q_data.size()) begin
        check({tag, "_row"},  q_row[base+i], i / 4);
        check({tag, "_col"},  q_col[base+i], i % 4);
        check({tag, "_data"}, q_data[base+i], exp_val(m, i / 4, i % 4));
      end
    end
  endtask

  int b, d0, p0, p1, n0;

  initial begin
    // Reset state
    step(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_row", rd_row, 0);
    rst_n = 1'b1;
    step(2);
    check("idle_busy", busy, 0);

    // Pass A: all ones, continuous drain
    out_ready = 1'b1;
    mode = 0; set_filter(0);
    b = q_data.size(); d0 = done_cnt; p0 = prod_rd; n0 = np_rd;
    pulse_start();
    check("a_busy", busy, 1);
    wait_done(d0, "a_done");
    check_seq(b, 0, "a");
    check("a_reads", (prod_rd - p0) + (np_rd - n0), 16);
    check("a_prod_reads", prod_rd - p0, 8);
    check("a_latency", lat, 3);
    step(3);
    check("a_busy_after", busy, 0);
    check("a_done_pulse", done_cnt - d0, 1);

    // Pass B: ramp pixels, single tap at (0,0)
    mode = 1; set_filter(1);
    b = q_data.size(); d0 = done_cnt;
    pulse_start();
    wait_done(d0, "b_done");
    check_seq(b, 1, "b");
    if (q_data.size() > b + 6) check("b_win_1_2", q_data[b+6], 10);

    // Pass C: backpressure mid-pass
    b = q_data.size(); d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 100 && !out_valid; i++) step(1);
    check("c_first_valid", out_valid, 1);
    out_ready = 1'b0;
    p0 = prod_rd; n0 = np_rd;
    step(10);
    p1 = prod_rd;
    step(30);
    check("c_no_prod_reads", prod_rd - p1, 0);
    check("c_warmup_reads", np_rd - n0, 4);
    check("c_buffered", dut.u_fifo.count, 4);
    check("c_held_valid", out_valid, 1);
    check("c_held_row", out_row, 0);
    check("c_held_col", out_col, 0);
    check("c_no_pops", q_data.size() - b, 0);
    out_ready = 1'b1;
    wait_done(d0, "c_done");
    check_seq(b, 1, "c");

    // Pass D: signed extremes
    mode = 2; set_filter(2);
    b = q_data.size(); d0 = done_cnt;
    pulse_start();
    wait_done(d0, "d_done");
    check_seq(b, 2, "d");

    // Pass E: reset during RUN, then a clean pass
    mode = 1; set_filter(1);
    d0 = done_cnt;
    pulse_start();
    step(8);
    rst_n = 1'b0;
    step(1);
    check("e_rst_busy", busy, 0);
    check("e_rst_rd_en", rd_en, 0);
    check("e_rst_valid", out_valid, 0);
    check("e_rst_data", out_data, 0);
    check("e_rst_done", done, 0);
    rst_n = 1'b1;
    step(10);
    check("e_no_done", done_cnt - d0, 0);
    check("e_idle", busy, 0);
    b = q_data.size();
    pulse_start();
    wait_done(d0, "e_done");
    check_seq(b, 1, "e");

    // Pass F: start pulsed while busy
    b = q_data.size(); d0 = done_cnt;
    pulse_start();
    step(6);
    pulse_start();
    step(1);
    wait_done(d0, "f_done");
    step(10);
    check("f_one_done", done_cnt - d0, 1);
    check("f_idle", busy, 0);
    check_seq(b, 1, "f");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
